// File: rtl/instruction_fetch_data.sv
// Second instruction-fetch stage: tag compare, data BRAM read, and miss handling.
// On a miss the line is filled into a round-robin victim way, and the new tag is then written back to the tag stage.
module instruction_fetch_data #(
  parameter int ICACHE_NUM_WAYS = 4,
  parameter int ICACHE_NUM_SETS = 64,
  parameter int CL_BYTES        = 64,
  localparam int SET_BITS  = $clog2(ICACHE_NUM_SETS),
  localparam int OFF_BITS  = $clog2(CL_BYTES),
  localparam int TAG_BITS  = 32 - SET_BITS - OFF_BITS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ift_valid,
  input  logic [31:0]                         ift_fetched_pc,
  input  logic [ICACHE_NUM_WAYS*TAG_BITS-1:0] ift_tags_read,
  input  logic [ICACHE_NUM_WAYS-1:0]          ift_valid_bits,
  input  logic                                wb_do_branch,
  output logic                                cache_miss,
  output logic                                resume_fetch,
  output logic [ICACHE_NUM_WAYS-1:0]          update_tag_en,
  output logic [SET_BITS-1:0]                 update_tag_set,
  output logic [TAG_BITS-1:0]                 update_tag,
  output logic                                mem_rd_req,
  output logic [31:0]                         mem_rd_addr,
  input  logic                                mem_rd_ready,
  input  logic                                mem_rd_data_valid,
  input  logic [31:0]                         mem_rd_data,
  output logic                                ifd_valid,
  output logic [31:0]                         ifd_pc,
  output logic [31:0]                         ifd_instr
);

  localparam int CL_WORDS  = CL_BYTES / 4;
  localparam int WORD_BITS = OFF_BITS - 2;
  localparam int WAY_BITS  = (ICACHE_NUM_WAYS > 1) ? $clog2(ICACHE_NUM_WAYS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_RESUME = 3'd4;

  logic [2:0]                 r_state;
  logic [31:0]                r_fill_addr;
  logic [SET_BITS-1:0]        r_fill_set;
  logic [TAG_BITS-1:0]        r_fill_tag;
  logic [WAY_BITS-1:0]        r_victim;
  logic [WAY_BITS-1:0]        r_victim_ctr;
  logic [WORD_BITS-1:0]       r_beat;
  logic                       r_ifd_valid;
  logic [31:0]                r_ifd_pc;
  logic [31:0]                r_ifd_instr;
  logic [31:0]                r_data [ICACHE_NUM_WAYS][ICACHE_NUM_SETS*CL_WORDS];

  logic [TAG_BITS-1:0]        w_tag;
  logic [SET_BITS-1:0]        w_set;
  logic [WORD_BITS-1:0]       w_word;
  logic [ICACHE_NUM_WAYS-1:0] w_hit;
  logic                       w_any_hit;
  logic [WAY_BITS-1:0]        w_hit_way;
  logic                       w_idle;
  logic                       w_fetch_ok;
  logic                       w_fire;
  logic                       w_start;
  logic                       w_unused;

  assign w_tag    = ift_fetched_pc[31:SET_BITS+OFF_BITS];
  assign w_set    = ift_fetched_pc[SET_BITS+OFF_BITS-1:OFF_BITS];
  assign w_word   = ift_fetched_pc[OFF_BITS-1:2];
  assign w_unused = ^ift_fetched_pc[1:0];

  // Lowest-index way wins when several ways report a hit.
  always_comb begin
    w_hit     = '0;
    w_any_hit = 1'b0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < ICACHE_NUM_WAYS; w++) begin
      w_hit[w] = ift_valid_bits[w] && (ift_tags_read[w*TAG_BITS +: TAG_BITS] == w_tag);
      if (w_hit[w] && !w_any_hit) begin
        w_any_hit = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
    end
  end

  assign w_idle     = (r_state == S_IDLE);
  assign w_fetch_ok = ift_valid && !wb_do_branch;
  assign w_fire     = w_fetch_ok && w_idle && w_any_hit;
  assign w_start    = w_fetch_ok && w_idle && !w_any_hit;
  assign cache_miss = w_fetch_ok && (!w_idle || !w_any_hit);

  always_ff @(posedge clk) begin
    if (!rst && r_state == S_FILL && mem_rd_data_valid)
      r_data[r_victim][{r_fill_set, r_beat}] <= mem_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifd_valid <= 1'b0;
      r_ifd_pc    <= '0;
      r_ifd_instr <= '0;
    end else begin
      r_ifd_valid <= w_fire;
      if (w_fire) begin
        r_ifd_pc    <= ift_fetched_pc;
        r_ifd_instr <= r_data[w_hit_way][{w_set, w_word}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_fill_addr  <= '0;
      r_fill_set   <= '0;
      r_fill_tag   <= '0;
      r_victim     <= '0;
      r_victim_ctr <= '0;
      r_beat       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_fill_addr  <= {ift_fetched_pc[31:OFF_BITS], {OFF_BITS{1'b0}}};
          r_fill_set   <= w_set;
          r_fill_tag   <= w_tag;
          r_victim     <= r_victim_ctr;
          r_victim_ctr <= r_victim_ctr + 1'b1;
          r_beat       <= '0;
          r_state      <= S_REQ;
        end
        S_REQ: if (mem_rd_ready) r_state <= S_FILL;
        S_FILL: if (mem_rd_data_valid) begin
          r_beat <= r_beat + 1'b1;
          if (r_beat == WORD_BITS'(CL_WORDS - 1)) r_state <= S_UPDATE;
        end
        S_UPDATE: r_state <= S_RESUME;
        S_RESUME: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd_req     = (r_state == S_REQ);
  assign mem_rd_addr    = r_fill_addr;
  assign resume_fetch   = (r_state == S_RESUME);
  assign update_tag_en  = (r_state == S_UPDATE) ? (ICACHE_NUM_WAYS'(1) << r_victim) : '0;
  assign update_tag_set = r_fill_set;
  assign update_tag     = r_fill_tag;
  assign ifd_valid      = r_ifd_valid;
  assign ifd_pc         = r_ifd_pc;
  assign ifd_instr      = r_ifd_instr;

endmodule

// File: tb/tb_instruction_fetch_data.sv
// Directed bench for instruction_fetch_data: miss/fill, hits, round-robin victims, redirects, busy reject, reset mid-fill.
module tb_instruction_fetch_data;

  logic        clk = 1'b0;
  logic        rst;
  logic        ift_valid;
  logic [31:0] ift_fetched_pc;
  logic [79:0] ift_tags_read;
  logic [3:0]  ift_valid_bits;
  logic        wb_do_branch;
  logic        cache_miss;
  logic        resume_fetch;
  logic [3:0]  update_tag_en;
  logic [5:0]  update_tag_set;
  logic [19:0] update_tag;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ready;
  logic        mem_rd_data_valid;
  logic [31:0] mem_rd_data;
  logic        ifd_valid;
  logic [31:0] ifd_pc;
  logic [31:0] ifd_instr;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_data #(
    .ICACHE_NUM_WAYS(4),
    .ICACHE_NUM_SETS(64),
    .CL_BYTES(64)
  ) dut (
    .clk(clk), .rst(rst),
    .ift_valid(ift_valid), .ift_fetched_pc(ift_fetched_pc),
    .ift_tags_read(ift_tags_read), .ift_valid_bits(ift_valid_bits),
    .wb_do_branch(wb_do_branch), .cache_miss(cache_miss),
    .resume_fetch(resume_fetch), .update_tag_en(update_tag_en),
    .update_tag_set(update_tag_set), .update_tag(update_tag),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ready(mem_rd_ready), .mem_rd_data_valid(mem_rd_data_valid),
    .mem_rd_data(mem_rd_data), .ifd_valid(ifd_valid),
    .ifd_pc(ifd_pc), .ifd_instr(ifd_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wd(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ifd_valid"}, 64'(ifd_valid), 64'd0);
    chk({tag, "_ifd_pc"},    64'(ifd_pc), 64'd0);
    chk({tag, "_ifd_instr"}, 64'(ifd_instr), 64'd0);
    chk({tag, "_resume"},    64'(resume_fetch), 64'd0);
    chk({tag, "_req"},       64'(mem_rd_req), 64'd0);
    chk({tag, "_addr"},      64'(mem_rd_addr), 64'd0);
    chk({tag, "_upd_en"},    64'(update_tag_en), 64'd0);
    chk({tag, "_miss"},      64'(cache_miss), 64'd0);
  endtask

  // Present a missing fetch; leaves the DUT in the request state.
  task automatic miss(input logic [31:0] pc);
    ift_valid      = 1'b1;
    ift_fetched_pc = pc;
    ift_valid_bits = 4'b0000;
    #1 chk("miss_flag", 64'(cache_miss), 64'd1);
    tick();
    ift_valid = 1'b0;
  endtask

  task automatic hit(input logic [31:0] pc, input logic [19:0] t, input logic [3:0] vb,
                     input logic [31:0] exp_instr);
    ift_valid      = 1'b1;
    ift_fetched_pc = pc;
    ift_tags_read  = {4{t}};
    ift_valid_bits = vb;
    #1 chk("hit_no_miss", 64'(cache_miss), 64'd0);
    tick();
    ift_valid = 1'b0;
    chk("hit_valid", 64'(ifd_valid), 64'd1);
    chk("hit_pc",    64'(ifd_pc), 64'(pc));
    chk("hit_instr", 64'(ifd_instr), 64'(exp_instr));
  endtask

  // Serve one line fill. gap = idle cycles before each beat; inj = beat before which a
  // hitting fetch is presented; rstb = beat at which rst is asserted (fill abandoned).
  task automatic fill(input logic [31:0] a, input logic [3:0] en, input int gap,
                      input int inj, input int rstb);
    #1;
    chk("req_on",   64'(mem_rd_req), 64'd1);
    chk("req_addr", 64'(mem_rd_addr), 64'(a));
    tick();
    chk("req_held", 64'(mem_rd_req), 64'd1);
    mem_rd_ready = 1'b1;
    tick();
    mem_rd_ready = 1'b0;
    chk("req_drop", 64'(mem_rd_req), 64'd0);
    for (int b = 0; b < 16; b++) begin
      if (b == inj) begin
        ift_valid      = 1'b1;
        ift_fetched_pc = 32'h0000_2104;
        ift_tags_read  = {4{20'h00002}};
        ift_valid_bits = 4'b1111;
        #1 chk("busy_miss", 64'(cache_miss), 64'd1);
        tick();
        ift_valid = 1'b0;
        chk("busy_no_valid", 64'(ifd_valid), 64'd0);
      end
      for (int g = 0; g < gap; g++) tick();
      if (b == 15) chk("no_early_update", 64'(update_tag_en), 64'd0);
      mem_rd_data_valid = 1'b1;
      mem_rd_data       = wd(a + 32'(4 * b));
      if (b == rstb) rst = 1'b1;
      tick();
      mem_rd_data_valid = 1'b0;
      if (b == rstb) begin
        rst = 1'b0;
        chk_idle_outputs("rst_fill");
        for (int c = b + 1; c < 16; c++) begin
          for (int g = 0; g < gap; g++) tick();
          mem_rd_data_valid = 1'b1;
          mem_rd_data       = 32'hDEAD_BEEF;
          tick();
          mem_rd_data_valid = 1'b0;
          chk("ignored_upd", 64'(update_tag_en), 64'd0);
          chk("ignored_req", 64'(mem_rd_req), 64'd0);
        end
        tick();
        chk("ignored_resume", 64'(resume_fetch), 64'd0);
        return;
      end
    end
    chk("upd_en",     64'(update_tag_en), 64'(en));
    chk("upd_set",    64'(update_tag_set), 64'(a[11:6]));
    chk("upd_tag",    64'(update_tag), 64'(a[31:12]));
    chk("resume_pre", 64'(resume_fetch), 64'd0);
    tick();
    chk("resume_on",  64'(resume_fetch), 64'd1);
    chk("upd_en_off", 64'(update_tag_en), 64'd0);
    tick();
    chk("resume_off", 64'(resume_fetch), 64'd0);
  endtask

  initial begin
    rst = 1'b1; ift_valid = 1'b0; ift_fetched_pc = '0; ift_tags_read = '0;
    ift_valid_bits = '0; wb_do_branch = 1'b0; mem_rd_ready = 1'b0;
    mem_rd_data_valid = 1'b0; mem_rd_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk_idle_outputs("reset");

    // Cold miss on 0x100 (set 4, tag 0) into way 0, then hit on 0x104.
    miss(32'h0000_0100);
    fill(32'h0000_0100, 4'b0001, 0, -1, -1);
    hit(32'h0000_0104, 20'h0, 4'b0001, wd(32'h0000_0104));
    tick();
    chk("hit_valid_drop", 64'(ifd_valid), 64'd0);

    // Round-robin from a fresh victim counter: tags 1..5 into set 4.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      miss(32'(t << 12) | 32'h100);
      fill(32'(t << 12) | 32'h100, 4'b0001 << ((t - 1) % 4), 0, -1, -1);
    end
    // Ways 1..3 all claim tag 2; way 1 holds tag 2's line.
    hit(32'h0000_2108, 20'h00002, 4'b1110, wd(32'h0000_2108));

    // Redirect squashes a hit and suppresses a miss.
    ift_valid = 1'b1; wb_do_branch = 1'b1; ift_fetched_pc = 32'h0000_2104;
    ift_tags_read = {4{20'h00002}}; ift_valid_bits = 4'b1111;
    #1 chk("br_hit_miss", 64'(cache_miss), 64'd0);
    tick();
    chk("br_hit_squash", 64'(ifd_valid), 64'd0);
    ift_valid_bits = 4'b0000;
    #1 chk("br_miss_flag", 64'(cache_miss), 64'd0);
    tick();
    ift_valid = 1'b0; wb_do_branch = 1'b0;
    chk("br_miss_idle", 64'(mem_rd_req), 64'd0);

    // Busy reject: hitting fetch during the fill of tag 7 (victim way 1).
    miss(32'h0000_7100);
    fill(32'h0000_7100, 4'b0010, 0, 5, -1);

    // Gapped fill of tag 9 into way 2; then reset partway through tag 0xA's fill.
    miss(32'h0000_9100);
    fill(32'h0000_9100, 4'b0100, 2, -1, -1);
    hit(32'h0000_9124, 20'h00009, 4'b0100, wd(32'h0000_9124));
    miss(32'h0000_A100);
    fill(32'h0000_A100, 4'b1000, 2, -1, 7);

    // Victim counter restarts at way 0 after reset.
    miss(32'h0000_B100);
    fill(32'h0000_B100, 4'b0001, 0, -1, -1);
    hit(32'h0000_B13C, 20'h0000B, 4'b0001, wd(32'h0000_B13C));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
